// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues 1-cycle-latency cache reads
// and buffers {instr, pc} pairs in an in-order show-ahead FIFO for dispatch.
module instruction_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fetch_req,
  output logic [31:0] fetch_pc,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_data,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        deq,
  output logic        ifq_empty,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_OCC = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     pc, pc_q;
  logic            req_q;
  logic            enq, do_deq, full;
  logic [CW:0]     occ;

  // Occupancy includes the in-flight response so a response never finds the queue full.
  assign occ       = {1'b0, count} + {{CW{1'b0}}, req_q};
  assign full      = (count == DEPTH_CNT);
  assign ifq_empty = (count == '0);
  assign fetch_req = ~rst & ~flush & (occ < DEPTH_OCC);
  assign fetch_pc  = pc;

  assign enq    = fetch_valid & req_q & ~flush & ~full;
  assign do_deq = deq & ~ifq_empty & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      pc_q   <= RESET_PC;
      req_q  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      pc     <= flush_pc;
      req_q  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      req_q <= fetch_req;
      if (fetch_req) begin
        pc   <= pc + 32'd4;
        pc_q <= pc;
      end
      if (enq)    wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= '{instr: fetch_data, pc: pc_q};
  end

  assign head           = mem[rd_ptr];
  assign instr          = ifq_empty ? 32'h0 : head.instr;
  assign instr_pc       = ifq_empty ? 32'h0 : head.pc;
  assign instr_pc_plus4 = ifq_empty ? 32'h0 : head.pc + 32'd4;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue with a 1-cycle cache model
// returning pc ^ 32'hA5A5_0000.
module tb_instruction_fetch_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        flush;
  logic [31:0] flush_pc;
  logic        deq;
  logic        ifq_empty;
  logic [31:0] instr, instr_pc, instr_pc_plus4;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  instruction_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .flush(flush), .flush_pc(flush_pc),
    .deq(deq), .ifq_empty(ifq_empty),
    .instr(instr), .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4)
  );

  always #5 clk = ~clk;

  // Cache model: answers every request one cycle later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_valid <= 1'b0;
      fetch_data  <= 32'h0;
    end else begin
      fetch_valid <= fetch_req;
      fetch_data  <= fetch_pc ^ KEY;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] epc);
    chk({tag, " empty"}, {31'h0, ifq_empty}, 32'h0);
    chk({tag, " instr_pc"}, instr_pc, epc);
    chk({tag, " instr"}, instr, epc ^ KEY);
    chk({tag, " pc_plus4"}, instr_pc_plus4, epc + 32'd4);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; flush_pc = 32'h0; deq = 1'b0;
    #3;
    chk("rst fetch_req", {31'h0, fetch_req}, 32'h0);
    chk("rst empty", {31'h0, ifq_empty}, 32'h1);
    chk("rst instr", instr, 32'h0);
    chk("rst instr_pc", instr_pc, 32'h0);
    chk("rst pc_plus4", instr_pc_plus4, 32'h0);

    // Fill from RESET_PC with no dequeue.
    @(negedge clk); rst = 1'b0; #1;
    chk("c0 fetch_req", {31'h0, fetch_req}, 32'h1);
    chk("c0 fetch_pc", fetch_pc, 32'h0);
    step();
    chk("c1 fetch_req", {31'h0, fetch_req}, 32'h1);
    chk("c1 fetch_pc", fetch_pc, 32'h4);
    chk("c1 empty", {31'h0, ifq_empty}, 32'h1);
    step();
    chk("c2 fetch_pc", fetch_pc, 32'h8);
    chk_head("c2", 32'h0);
    step();
    chk("c3 fetch_req", {31'h0, fetch_req}, 32'h1);
    chk("c3 fetch_pc", fetch_pc, 32'hC);
    step();
    chk("c4 fetch_req", {31'h0, fetch_req}, 32'h0);
    step();
    chk("c5 fetch_req full", {31'h0, fetch_req}, 32'h0);
    chk_head("c5", 32'h0);

    // Dequeue every cycle: a pop while full re-enables fetch next cycle.
    deq = 1'b1;
    step();
    chk("c6 fetch_req", {31'h0, fetch_req}, 32'h1);
    chk("c6 fetch_pc", fetch_pc, 32'h10);
    chk_head("c6", 32'h4);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_head("stream", 32'h8 + 32'(i) * 32'd4);
    end

    // Stop popping so count reaches 3 with a response in flight.
    deq = 1'b0;
    step();
    chk_head("c12", 32'h18);
    chk("c12 fetch_req", {31'h0, fetch_req}, 32'h0);
    chk("c12 in flight", {31'h0, fetch_valid}, 32'h1);
    flush = 1'b1; flush_pc = 32'h100; #1;
    chk("flush fetch_req", {31'h0, fetch_req}, 32'h0);

    step();
    flush = 1'b0; deq = 1'b1; #1;
    chk("f+1 empty", {31'h0, ifq_empty}, 32'h1);
    chk("f+1 fetch_req", {31'h0, fetch_req}, 32'h1);
    chk("f+1 fetch_pc", fetch_pc, 32'h100);
    chk("f+1 instr", instr, 32'h0);
    step();
    chk("f+2 empty", {31'h0, ifq_empty}, 32'h1);
    chk("f+2 fetch_pc", fetch_pc, 32'h104);
    step();
    chk_head("f+3", 32'h100);
    step();
    chk_head("f+4", 32'h104);
    step();
    chk_head("f+5", 32'h108);

    // Build count=3, then pulse reset between edges.
    deq = 1'b0;
    step();
    chk_head("hold1", 32'h108);
    step();
    chk_head("hold2", 32'h108);
    #1 rst = 1'b1; #1;
    chk("arst empty", {31'h0, ifq_empty}, 32'h1);
    chk("arst fetch_req", {31'h0, fetch_req}, 32'h0);
    chk("arst instr_pc", instr_pc, 32'h0);
    #1 rst = 1'b0; #1;
    chk("rel fetch_req", {31'h0, fetch_req}, 32'h1);
    chk("rel fetch_pc", fetch_pc, 32'h0);
    step();
    chk("rel+1 empty", {31'h0, ifq_empty}, 32'h1);
    chk("rel+1 fetch_pc", fetch_pc, 32'h4);
    step();
    chk_head("rel+2", 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    if (n_err != 0) $error("instruction_fetch_queue bench saw %0d bad comparisons", n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Instruction fetch queue (IFQ) feeding the dispatch unit of the Tomasulo core. It owns the fetch PC and issues fixed-latency requests to the instruction cache. It buffers returned instructions, each tagged with its PC, in an in-order FIFO, and presents the head entry to dispatch with an `ifq_empty` flag. Dispatch pops the head with its non-stall signal. A resolved control transfer flushes the queue, squashes the in-flight response and redirects fetch.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `RESET_PC`, 32'h0000_0000: fetch PC loaded on reset.

Ports:
- `clk`  in  1: sole clock, rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `fetch_req`  out  1: cache read request this cycle.
- `fetch_pc`  out  32: address of the request; the current PC register.
- `fetch_valid`  in  1: cache response valid; arrives exactly 1 cycle after `fetch_req`.
- `fetch_data`  in  32: instruction word returned by the cache.
- `flush`  in  1: redirect request (branch taken, jal or jalr resolved).
- `flush_pc`  in  32: redirect target.
- `deq`  in  1: dispatch pops the head entry (the dispatch unit's `nstall`).
- `ifq_empty`  out  1: no valid entry.
- `instr`  out  32: head instruction; 0 when empty.
- `instr_pc`  out  32: PC of the head instruction; 0 when empty.
- `instr_pc_plus4`  out  32: `instr_pc` + 4, truncated to 32 bits; 0 when empty.

## Operation
- State: storage array of {instr, pc} × DEPTH; `wr_ptr` and `rd_ptr` (log2 DEPTH bits, natural wrap); `count` (log2 DEPTH + 1 bits, 0..DEPTH); `pc` register; `req_q` (fetch issued last cycle); `pc_q` (PC of that request).
- Reset (async): `pc`=RESET_PC, pointers=0, `count`=0, `req_q`=0. While `rst` is high, `fetch_req`=0 and `ifq_empty`=1. `instr`, `instr_pc` and `instr_pc_plus4` are 0.
- Fetch: `fetch_req` = ~rst & ~flush & ((count + req_q) < DEPTH). On `fetch_req`: `pc` ← `pc` + 4 (wraps mod 2^32), `req_q` ← 1, `pc_q` ← `pc`. Otherwise `req_q` ← 0.
- Enqueue: when `fetch_valid` & `req_q` & ~`flush`, write {`fetch_data`, `pc_q`} at `wr_ptr` and advance `wr_ptr`.
  - `fetch_valid` without `req_q` is ignored.
  - By construction the queue is never full when a response arrives. A response that arrives while full is dropped, and the bench flags it as an error.
- Dequeue: when `deq` & ~`ifq_empty` & ~`flush`, advance `rd_ptr`. `deq` while empty is ignored.
- Count: +1 on enqueue only, −1 on dequeue only, unchanged when both or neither occur.
- Flush, highest priority, takes effect at the clock edge:
  - pointers, `count` and `req_q` are cleared; `pc` ← `flush_pc`.
  - any response arriving in the flush cycle is discarded.
  - `deq` is ignored in that cycle.
  - no request is issued in the flush cycle.
- Head outputs are combinational from `rd_ptr`, i.e. show-ahead. `ifq_empty` = (`count` == 0).

## Timing
- Request to visible at head: 2 cycles. Request issued in cycle N, response in N+1 written at the end of N+1, `ifq_empty` falls in N+2.
- After reset release: the first request is in the first cycle, with `fetch_pc`=RESET_PC. One request per cycle follows until count + req_q reaches DEPTH.
- With continuous `deq` and no flush, steady state is one instruction per cycle after a 2-cycle fill.
- Flush in cycle N: outputs are empty in N+1. `fetch_req`=1 with `fetch_pc`=`flush_pc` in N+1. First redirected instruction is at the head in N+3.
- A full queue deasserts `fetch_req`. A `deq` in cycle N lets a request be issued in N+1.
- Reset asserted mid-operation clears all state immediately, with no clock edge needed. Queue contents are lost.

## Test plan
- Reset with RESET_PC=0, DEPTH=4, no `deq`, cache returning `fetch_data`=pc^32'hA5A5_0000:
  - `fetch_pc` 0,4,8,C on four consecutive cycles, then `fetch_req`=0.
  - `ifq_empty`=0 from cycle 2; head `instr_pc`=0, `instr_pc_plus4`=4.
- Fill, then `deq` every cycle: heads appear in order with `instr_pc`=0,4,8,C,10,14…. `instr` matches the stored data. Count oscillates only within 0..4.
- Flush with `flush_pc`=0x100 while a response is in flight and count=3:
  - next cycle `ifq_empty`=1 and `fetch_pc`=0x100.
  - the in-flight word never appears at the head.
  - first head after the flush has `instr_pc`=0x100.
- `deq` while empty with `flush`=0: `count` stays 0, no pointer movement, and the first later instruction is not skipped.
- Count=2 with an enqueue and `deq` in the same cycle: count stays 2 and order is preserved.
- `rst` pulsed asynchronously mid-stream at count=3: `ifq_empty`=1 and `fetch_req`=0 immediately. After release, fetch restarts at RESET_PC.
